// File: rtl/ifetch_tag_stage_rr_pkg.sv
// Shared definitions for the ifetch tag stage: PC stride, index-width and
// bus-width helpers, and the PC-to-set-index helper.
package ifetch_tag_stage_rr_pkg;

  // Sequential fetch advances one 32-bit instruction at a time.
  localparam int unsigned PC_STEP = 4;

  // Index width for a power-of-two count; never returns zero.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of the {pc, warp_idx} bus carried to the ifetch data stage.
  function automatic int unsigned ift_to_ifd_bus_w(input int unsigned addr_w,
                                                   input int unsigned num_warps);
    return addr_w + idx_w(num_warps);
  endfunction

  // L1I set index of a PC: the bits just above the line offset.
  function automatic logic [31:0] pc_to_set(input logic [63:0] pc,
                                            input int unsigned ofs_w,
                                            input int unsigned set_w);
    logic [63:0] shifted;
    logic [63:0] mask;
    shifted = pc >> ofs_w;
    mask    = (64'd1 << set_w) - 64'd1;
    return 32'(shifted & mask);
  endfunction

endpackage

// File: rtl/ifetch_tag_stage_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// wrapping from N-1 to 0. Purely combinational; the caller owns the pointer.
module ifetch_tag_stage_rr_arbiter
  import ifetch_tag_stage_rr_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = idx_w(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt_oh,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_valid
);

  logic [IDX_W-1:0] idx;

  // Scan N candidates starting at ptr; N is a power of two so IDX_W wraps.
  always_comb begin
    gnt_oh    = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    idx       = '0;
    for (int i = 0; i < int'(N); i++) begin
      idx = ptr + IDX_W'(i);
      if (!gnt_valid && req[idx]) begin
        gnt_valid    = 1'b1;
        gnt_idx      = idx;
        gnt_oh[idx]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ifetch_tag_stage_rr.sv
// Ifetch tag stage: round-robin warp selection, icache tag lookup request and
// {pc, warp} register toward the ifetch data stage. Keeps per-warp PCs and a
// sleep bitmap driven by icache misses, L2 wakes and writeback rollbacks.
// Optional feature macro: IFETCH_TAG_PERF_CNT_EN adds saturating fetch/idle
// performance counters and their output ports.
module ifetch_tag_stage_rr
  import ifetch_tag_stage_rr_pkg::*;
#(
  parameter int unsigned          NUM_WARPS      = 4,
  parameter int unsigned          ADDR_WIDTH     = 32,
  parameter int unsigned          NUM_SETS       = 64,
  parameter int unsigned          LINE_BYTES     = 64,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC      = '0,
  parameter int unsigned          PERF_CNT_WIDTH = 32,
  localparam int unsigned         WARP_IDX_W     = idx_w(NUM_WARPS),
  localparam int unsigned         SET_W          = $clog2(NUM_SETS),
  localparam int unsigned         OFS_W          = $clog2(LINE_BYTES),
  localparam int unsigned         BUS_W          = ift_to_ifd_bus_w(ADDR_WIDTH, NUM_WARPS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_WARPS-1:0]      warp_en_bitmap,
  input  logic                      ifd_allowin,
  input  logic                      ifd_cache_miss,
  input  logic                      ifd_near_miss,
  input  logic [WARP_IDX_W-1:0]     ifd_cache_miss_warp_idx,
  input  logic [ADDR_WIDTH-1:0]     ifd_cache_miss_pc,
  input  logic [NUM_WARPS-1:0]      l2i_to_ift_wake_bitmap,
  input  logic                      wb_rollback_en,
  input  logic [WARP_IDX_W-1:0]     wb_rollback_warp_idx,
  input  logic [ADDR_WIDTH-1:0]     wb_rollback_pc,
  output logic                      ift_to_ifd_valid,
  output logic [BUS_W-1:0]          ift_to_ifd_bus,
  output logic                      ift_to_icache_fetch_en,
  output logic [SET_W-1:0]          ift_to_icache_fetch_set_idx
`ifdef IFETCH_TAG_PERF_CNT_EN
  ,
  output logic [PERF_CNT_WIDTH-1:0] perf_fetch_cnt,
  output logic [PERF_CNT_WIDTH-1:0] perf_idle_cnt
`endif
);

  // Handshake toward the data stage: the output register holds one entry;
  // it transfers on a clock edge where ift_to_ifd_valid & ifd_allowin. A new
  // entry may be loaded when the register is empty or transferring
  // (can_issue); otherwise the entry and all PCs hold unchanged.

  logic [ADDR_WIDTH-1:0] pc_q [NUM_WARPS];
  logic [NUM_WARPS-1:0]  sleep_q;
  logic [WARP_IDX_W-1:0] rr_ptr_q;

  logic [NUM_WARPS-1:0]  rb_oh;
  logic [NUM_WARPS-1:0]  miss_oh;
  logic [NUM_WARPS-1:0]  eligible;
  logic [NUM_WARPS-1:0]  gnt_oh;
  logic [WARP_IDX_W-1:0] gnt_idx;
  logic                  gnt_valid;
  logic                  any_miss;
  logic                  hard_miss;
  logic                  can_issue;
  logic                  issue;
  logic                  squash;
  logic [WARP_IDX_W-1:0] out_warp;
  logic [ADDR_WIDTH-1:0] gnt_pc;

  assign any_miss  = ifd_cache_miss | ifd_near_miss;
  assign hard_miss = ifd_cache_miss & ~ifd_near_miss;
  assign out_warp  = ift_to_ifd_bus[WARP_IDX_W-1:0];
  assign gnt_pc    = pc_q[gnt_idx];

  // Decode the redirect sources into per-warp one-hot masks.
  always_comb begin
    rb_oh   = '0;
    miss_oh = '0;
    if (wb_rollback_en) rb_oh[wb_rollback_warp_idx] = 1'b1;
    if (any_miss)       miss_oh[ifd_cache_miss_warp_idx] = 1'b1;
  end

  // A warp being redirected this cycle must not issue its stale PC.
  assign eligible  = warp_en_bitmap & ~sleep_q & ~rb_oh & ~miss_oh;
  assign can_issue = ~ift_to_ifd_valid | ifd_allowin;
  assign issue     = can_issue & gnt_valid;
  assign squash    = (wb_rollback_en & (wb_rollback_warp_idx == out_warp)) |
                     (any_miss & (ifd_cache_miss_warp_idx == out_warp));

  ifetch_tag_stage_rr_arbiter #(
    .N     (NUM_WARPS),
    .IDX_W (WARP_IDX_W)
  ) u_arb (
    .req       (eligible),
    .ptr       (rr_ptr_q),
    .gnt_oh    (gnt_oh),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // Tag lookup request; forced quiet while reset is held.
  always_comb begin
    ift_to_icache_fetch_en      = issue & ~rst;
    ift_to_icache_fetch_set_idx = '0;
    if (!rst)
      ift_to_icache_fetch_set_idx = SET_W'(pc_to_set(64'(gnt_pc), OFS_W, SET_W));
  end

  // Per-warp PC and sleep: rollback beats miss; wake with a miss acts as near miss.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int w = 0; w < int'(NUM_WARPS); w++) pc_q[w] <= RESET_PC;
      sleep_q <= '0;
    end else begin
      for (int w = 0; w < int'(NUM_WARPS); w++) begin
        if (rb_oh[w]) begin
          pc_q[w]    <= wb_rollback_pc;
          sleep_q[w] <= 1'b0;
        end else if (miss_oh[w]) begin
          pc_q[w] <= ifd_cache_miss_pc;
          if (l2i_to_ift_wake_bitmap[w]) sleep_q[w] <= 1'b0;
          else if (hard_miss)            sleep_q[w] <= 1'b1;
        end else begin
          if (l2i_to_ift_wake_bitmap[w]) sleep_q[w] <= 1'b0;
          if (issue && gnt_oh[w])        pc_q[w] <= pc_q[w] + ADDR_WIDTH'(PC_STEP);
        end
      end
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ift_to_ifd_valid <= 1'b0;
      ift_to_ifd_bus   <= '0;
      rr_ptr_q         <= '0;
    end else if (issue) begin
      ift_to_ifd_valid <= 1'b1;
      ift_to_ifd_bus   <= {gnt_pc, gnt_idx};
      rr_ptr_q         <= gnt_idx + WARP_IDX_W'(1);
    end else if (ifd_allowin || squash) begin
      ift_to_ifd_valid <= 1'b0;
    end
  end

`ifdef IFETCH_TAG_PERF_CNT_EN
  // Saturating counters of issued fetches and of cycles with nothing eligible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_cnt <= '0;
      perf_idle_cnt  <= '0;
    end else begin
      if (issue && (perf_fetch_cnt != '1))    perf_fetch_cnt <= perf_fetch_cnt + 1'b1;
      if (!(|eligible) && (perf_idle_cnt != '1)) perf_idle_cnt <= perf_idle_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ifetch_tag_stage_rr.sv
// Directed bench for ifetch_tag_stage_rr with default parameters
// (4 warps, 32-bit PC, 64 sets, 64-byte lines -> set index = pc[11:6]).
module tb_ifetch_tag_stage_rr;

  localparam int NW    = 4;
  localparam int AW    = 32;
  localparam int WIW   = 2;
  localparam int SW    = 6;
  localparam int BW    = AW + WIW;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NW-1:0]  warp_en_bitmap;
  logic           ifd_allowin;
  logic           ifd_cache_miss;
  logic           ifd_near_miss;
  logic [WIW-1:0] ifd_cache_miss_warp_idx;
  logic [AW-1:0]  ifd_cache_miss_pc;
  logic [NW-1:0]  l2i_to_ift_wake_bitmap;
  logic           wb_rollback_en;
  logic [WIW-1:0] wb_rollback_warp_idx;
  logic [AW-1:0]  wb_rollback_pc;
  logic           ift_to_ifd_valid;
  logic [BW-1:0]  ift_to_ifd_bus;
  logic           ift_to_icache_fetch_en;
  logic [SW-1:0]  ift_to_icache_fetch_set_idx;

  ifetch_tag_stage_rr dut (
    .clk                         (clk),
    .rst                         (rst),
    .warp_en_bitmap              (warp_en_bitmap),
    .ifd_allowin                 (ifd_allowin),
    .ifd_cache_miss              (ifd_cache_miss),
    .ifd_near_miss               (ifd_near_miss),
    .ifd_cache_miss_warp_idx     (ifd_cache_miss_warp_idx),
    .ifd_cache_miss_pc           (ifd_cache_miss_pc),
    .l2i_to_ift_wake_bitmap      (l2i_to_ift_wake_bitmap),
    .wb_rollback_en              (wb_rollback_en),
    .wb_rollback_warp_idx        (wb_rollback_warp_idx),
    .wb_rollback_pc              (wb_rollback_pc),
    .ift_to_ifd_valid            (ift_to_ifd_valid),
    .ift_to_ifd_bus              (ift_to_ifd_bus),
    .ift_to_icache_fetch_en      (ift_to_icache_fetch_en),
    .ift_to_icache_fetch_set_idx (ift_to_icache_fetch_set_idx)
  );

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [BW-1:0] mk(input logic [AW-1:0] pc, input logic [WIW-1:0] w);
    return {pc, w};
  endfunction

  // scoreboard compare
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_fetch(input string tag, input logic en, input logic [SW-1:0] set);
    #1;
    chk({tag, "_fetch_en"}, 64'(ift_to_icache_fetch_en), 64'(en));
    if (en) chk({tag, "_set_idx"}, 64'(ift_to_icache_fetch_set_idx), 64'(set));
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [BW-1:0] bus);
    chk({tag, "_valid"}, 64'(ift_to_ifd_valid), 64'(v));
    if (v) chk({tag, "_bus"}, 64'(ift_to_ifd_bus), 64'(bus));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_events();
    ifd_cache_miss          = 1'b0;
    ifd_near_miss           = 1'b0;
    ifd_cache_miss_warp_idx = '0;
    ifd_cache_miss_pc       = '0;
    l2i_to_ift_wake_bitmap  = '0;
    wb_rollback_en          = 1'b0;
    wb_rollback_warp_idx    = '0;
    wb_rollback_pc          = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    warp_en_bitmap = '0;
    ifd_allowin    = 1'b0;
    clear_events();
    repeat (2) @(posedge clk);
    #1;

    // reset state
    chk("rst_valid", 64'(ift_to_ifd_valid), 64'd0);
    chk("rst_bus", 64'(ift_to_ifd_bus), 64'd0);
    warp_en_bitmap = 4'b0001;
    ifd_allowin    = 1'b1;
    #1;
    chk("rst_fetch_en", 64'(ift_to_icache_fetch_en), 64'd0);

    // 1: single warp streams 0,4,8
    rst = 1'b0;
    chk_fetch("t1_c0", 1'b1, 6'd0);
    tick(); chk_out("t1_o0", 1'b1, mk(32'h0, 2'd0));
    chk_fetch("t1_c1", 1'b1, 6'd0);
    tick(); chk_out("t1_o1", 1'b1, mk(32'h4, 2'd0));
    tick(); chk_out("t1_o2", 1'b1, mk(32'h8, 2'd0));

    // 2: warps 0,1,3 round robin from a clean reset
    warp_en_bitmap = 4'b1011;
    rst = 1'b1; #1; rst = 1'b0;
    chk_fetch("t2_c0", 1'b1, 6'd0);
    tick(); chk_out("t2_o0", 1'b1, mk(32'h0, 2'd0));
    tick(); chk_out("t2_o1", 1'b1, mk(32'h0, 2'd1));
    tick(); chk_out("t2_o2", 1'b1, mk(32'h0, 2'd3));
    tick(); chk_out("t2_o3", 1'b1, mk(32'h4, 2'd0));
    tick(); chk_out("t2_o4", 1'b1, mk(32'h4, 2'd1));
    tick(); chk_out("t2_o5", 1'b1, mk(32'h4, 2'd3));

    // 3: miss on w0 at 0x8, others continue, wake refetches 0x8
    ifd_cache_miss = 1'b1; ifd_cache_miss_warp_idx = 2'd0; ifd_cache_miss_pc = 32'h8;
    chk_fetch("t3_c0", 1'b1, 6'd0);
    tick(); chk_out("t3_o0", 1'b1, mk(32'h8, 2'd1));
    clear_events();
    tick(); chk_out("t3_o1", 1'b1, mk(32'h8, 2'd3));
    tick(); chk_out("t3_o2", 1'b1, mk(32'hC, 2'd1));
    l2i_to_ift_wake_bitmap = 4'b0001;
    tick(); chk_out("t3_o3", 1'b1, mk(32'hC, 2'd3));
    clear_events();
    tick(); chk_out("t3_o4", 1'b1, mk(32'h8, 2'd0));

    // 4: back-pressure holds the register and all PCs
    ifd_allowin = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_fetch("t4_stall", 1'b0, 6'd0);
      tick(); chk_out("t4_hold", 1'b1, mk(32'h8, 2'd0));
    end
    ifd_allowin = 1'b1;
    tick(); chk_out("t4_resume", 1'b1, mk(32'h10, 2'd1));

    // 5: rollback w1 to 0x100 with a miss on w1; out reg (w1) squashed
    ifd_allowin = 1'b0;
    wb_rollback_en = 1'b1; wb_rollback_warp_idx = 2'd1; wb_rollback_pc = 32'h100;
    ifd_cache_miss = 1'b1; ifd_cache_miss_warp_idx = 2'd1; ifd_cache_miss_pc = 32'h40;
    chk_fetch("t5_c0", 1'b0, 6'd0);
    tick(); chk_out("t5_squash", 1'b0, '0);
    clear_events();
    ifd_allowin = 1'b1;
    warp_en_bitmap = 4'b0010;
    chk_fetch("t5_c1", 1'b1, 6'd4);
    tick(); chk_out("t5_o1", 1'b1, mk(32'h100, 2'd1));

    // 6: wake + hard miss on w2 same cycle -> stays awake, refetches miss pc
    warp_en_bitmap = 4'b0100;
    ifd_cache_miss = 1'b1; ifd_cache_miss_warp_idx = 2'd2; ifd_cache_miss_pc = 32'h2C0;
    l2i_to_ift_wake_bitmap = 4'b0100;
    chk_fetch("t6_c0", 1'b0, 6'd0);
    tick(); chk_out("t6_o0", 1'b0, '0);
    clear_events();
    chk_fetch("t6_c1", 1'b1, 6'd11);
    tick(); chk_out("t6_o1", 1'b1, mk(32'h2C0, 2'd2));

    // 6b: reset pulse mid-run drops the entry and reloads PCs
    warp_en_bitmap = 4'b1111;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 64'(ift_to_ifd_valid), 64'd0);
    chk("t6_rst_bus", 64'(ift_to_ifd_bus), 64'd0);
    chk("t6_rst_fetch_en", 64'(ift_to_icache_fetch_en), 64'd0);
    rst = 1'b0;
    chk_fetch("t6_c2", 1'b1, 6'd0);
    tick(); chk_out("t6_o2", 1'b1, mk(32'h0, 2'd0));
    tick(); chk_out("t6_o3", 1'b1, mk(32'h0, 2'd1));

    // 7: PC wraps past the top of the address space
    warp_en_bitmap = 4'b0001;
    wb_rollback_en = 1'b1; wb_rollback_warp_idx = 2'd0; wb_rollback_pc = 32'hFFFF_FFFC;
    chk_fetch("t7_c0", 1'b0, 6'd0);
    tick(); chk_out("t7_o0", 1'b0, '0);
    clear_events();
    chk_fetch("t7_c1", 1'b1, 6'h3F);
    tick(); chk_out("t7_o1", 1'b1, mk(32'hFFFF_FFFC, 2'd0));
    chk_fetch("t7_c2", 1'b1, 6'd0);
    tick(); chk_out("t7_o2", 1'b1, mk(32'h0, 2'd0));

    // 8: near miss on w0 replays at the miss pc without sleeping
    ifd_cache_miss = 1'b1; ifd_near_miss = 1'b1;
    ifd_cache_miss_warp_idx = 2'd0; ifd_cache_miss_pc = 32'h40;
    chk_fetch("t8_c0", 1'b0, 6'd0);
    tick(); chk_out("t8_o0", 1'b0, '0);
    clear_events();
    chk_fetch("t8_c1", 1'b1, 6'd1);
    tick(); chk_out("t8_o1", 1'b1, mk(32'h40, 2'd0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
